// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: a request handshake carrying operands and opcode,
// and a response handshake carrying the registered result and compare flags.
interface alu_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;
  logic        overflow;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops and bit-serial shifts (one bit per clock),
// with a valid/ready handshake on both sides and no request overlap.
module alu_seq (
  input  logic     clock,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  logic [1:0]  state;
  logic [4:0]  counter;
  logic        shift_right;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        op_valid;
  logic        is_shift;
  logic [31:0] alu_res;
  logic        alu_ovf;
  logic        not_equal;
  logic        less_than;

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = (state == DONE);

  // Signed compare uses the sign of A-B corrected by its overflow, so it holds across wraparound.
  always_comb begin
    sum       = bus.data_operandA + bus.data_operandB;
    diff      = bus.data_operandA - bus.data_operandB;
    add_ovf   = (bus.data_operandA[31] == bus.data_operandB[31]) && (sum[31] != bus.data_operandA[31]);
    sub_ovf   = (bus.data_operandA[31] != bus.data_operandB[31]) && (diff[31] != bus.data_operandA[31]);
    op_valid  = (bus.ctrl_ALUopcode <= OP_SRA);
    is_shift  = (bus.ctrl_ALUopcode == OP_SLL) || (bus.ctrl_ALUopcode == OP_SRA);
    not_equal = op_valid && (bus.data_operandA != bus.data_operandB);
    less_than = op_valid && (diff[31] ^ sub_ovf);
    alu_res   = '0;
    alu_ovf   = 1'b0;
    case (bus.ctrl_ALUopcode)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      OP_AND:  alu_res = bus.data_operandA & bus.data_operandB;
      OP_OR:   alu_res = bus.data_operandA | bus.data_operandB;
      OP_SLL:  alu_res = bus.data_operandA << bus.ctrl_ALUopcode[0];
      OP_SRA:  alu_res = bus.data_operandA;
      default: alu_res = '0;
    endcase
  end

  // data_result doubles as the shift register while in SHIFT; it only counts as a result in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      counter         <= '0;
      shift_right     <= 1'b0;
      bus.data_result <= '0;
      bus.isNotEqual  <= 1'b0;
      bus.isLessThan  <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.isNotEqual <= not_equal;
            bus.isLessThan <= less_than;
            bus.overflow   <= alu_ovf;
            if (is_shift && (bus.ctrl_shiftamt != 5'd0)) begin
              bus.data_result <= bus.data_operandA;
              counter         <= bus.ctrl_shiftamt;
              shift_right     <= (bus.ctrl_ALUopcode == OP_SRA);
              state           <= SHIFT;
            end else begin
              bus.data_result <= is_shift ? bus.data_operandA : alu_res;
              state           <= DONE;
            end
          end
        end
        SHIFT: begin
          if (shift_right) begin
            bus.data_result <= {bus.data_result[31], bus.data_result[31:1]};
          end else begin
            bus.data_result <= {bus.data_result[30:0], 1'b0};
          end
          counter <= counter - 5'd1;
          if (counter == 5'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes model results at acceptance, and a
// monitor pops and compares them whenever the DUT raises out_valid.
module tb_alu_seq;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  flags;
    int          lat;
    time         t_acc;
  } exp_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   bp_mode;
  exp_t scoreboard[$];
  exp_t held;
  logic prev_valid;

  alu_seq_if bus ();

  alu_seq dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic record_timeout(input string name);
    n_checks++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Reference model from the operation definitions, using wide signed arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] amt);
    exp_t r;
    longint sa;
    longint sb;
    longint wide;
    logic signed [31:0] sra_tmp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.result = '0;
    r.flags  = 3'b000;
    r.lat    = 1;
    r.t_acc  = 0;
    if (op <= 5'd5) begin
      r.flags[2] = (a != b);
      r.flags[1] = (sa < sb);
    end
    case (op)
      5'd0: begin
        wide = sa + sb;
        r.result   = wide[31:0];
        r.flags[0] = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      5'd1: begin
        wide = sa - sb;
        r.result   = wide[31:0];
        r.flags[0] = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      5'd2: r.result = a & b;
      5'd3: r.result = a | b;
      5'd4: begin
        r.result = a << amt;
        r.lat    = 1 + int'(amt);
      end
      5'd5: begin
        sra_tmp  = a;
        r.result = sra_tmp >>> amt;
        r.lat    = 1 + int'(amt);
      end
      default: r.result = '0;
    endcase
    return r;
  endfunction

  always @(negedge clock) begin
    if (bp_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
    else bus.out_ready = (bp_mode == 0);
  end

  // Monitor: first valid cycle of a response is compared against the scoreboard, later cycles for stability.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else if (bus.out_valid) begin
      check_output("in_ready_low_in_done", 32'(bus.in_ready), 32'd0);
      if (!prev_valid) begin
        if (scoreboard.size() == 0) begin
          record_timeout("unexpected_out_valid");
        end else begin
          e = scoreboard.pop_front();
          check_output("result", bus.data_result, e.result);
          check_output("flags_ne_lt_ovf", 32'({bus.isNotEqual, bus.isLessThan, bus.overflow}), 32'(e.flags));
          check_output("latency", 32'(int'(($time - e.t_acc + 5) / 10)), 32'(e.lat));
          held = e;
        end
      end else begin
        check_output("hold_result", bus.data_result, held.result);
        check_output("hold_flags", 32'({bus.isNotEqual, bus.isLessThan, bus.overflow}), 32'(held.flags));
      end
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] amt);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clock);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.in_ready) begin
      record_timeout("wait_in_ready");
      return;
    end
    bus.in_valid       = 1'b1;
    bus.ctrl_ALUopcode = op;
    bus.data_operandA  = a;
    bus.data_operandB  = b;
    bus.ctrl_shiftamt  = amt;
    @(posedge clock);
    e = model(op, a, b, amt);
    e.t_acc = $time;
    scoreboard.push_back(e);
    #1;
    bus.in_valid       = 1'b0;
    bus.ctrl_ALUopcode = 5'($urandom);
    bus.data_operandA  = $urandom;
    bus.data_operandB  = $urandom;
    bus.ctrl_shiftamt  = 5'($urandom);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((scoreboard.size() != 0 || bus.out_valid) && cnt < 400) begin
      @(negedge clock);
      cnt++;
    end
    if (cnt >= 400) record_timeout("drain");
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    n_checks = 0;
    n_pass   = 0;
    bp_mode  = 0;
    prev_valid = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_ALUopcode = '0;
    bus.ctrl_shiftamt = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_result", bus.data_result, 32'd0);
    check_output("rst_flags", 32'({bus.isNotEqual, bus.isLessThan, bus.overflow}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    apply_stimulus(5'd3, 32'hFFFFFF0F, 32'h00000000, 5'd0);
    drain();
    apply_stimulus(5'd2, 32'hFFFFFFFF, 32'h000000F0, 5'd0);
    drain();
    apply_stimulus(5'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0);
    drain();
    apply_stimulus(5'd1, 32'h80000000, 32'h00000001, 5'd0);
    drain();
    apply_stimulus(5'd5, 32'h80000000, 32'h00000000, 5'd31);
    drain();
    apply_stimulus(5'd4, 32'h12345678, 32'h0, 5'd0);
    drain();
    apply_stimulus(5'd4, 32'h00000001, 32'h0, 5'd31);
    drain();
    apply_stimulus(5'd9, 32'h1234, 32'h5678, 5'd3);
    drain();

    // Backpressure: hold DONE for five cycles, then release.
    bp_mode = 2;
    apply_stimulus(5'd1, 32'h00000005, 32'h00000009, 5'd0);
    repeat (5) begin
      @(negedge clock);
      #1;
      check_output("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_output("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    #2;
    bp_mode = 0;
    @(negedge clock);
    @(posedge clock);
    #1;
    check_output("bp_release", 32'(bus.out_valid), 32'd0);
    drain();

    // Reset in the middle of a 20-bit shift.
    apply_stimulus(5'd4, 32'h0000ABCD, 32'h0, 5'd20);
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    scoreboard.delete();
    #1;
    check_output("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("abort_result", bus.data_result, 32'd0);
    check_output("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
    apply_stimulus(5'd4, 32'h0000ABCD, 32'h0, 5'd20);
    drain();

    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 7));
      if (i % 10 == 9) op = 5'd31;
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      if (i % 5 == 1) a = {1'b0, a[30:0]} | 32'h40000000;
      apply_stimulus(op, a, b, 5'($urandom_range(0, 31)));
    end
    drain();
    bp_mode = 0;
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
